// File: rtl/fma16_pkg.sv
// fma16_pkg: flag bit positions, rounding-mode codes, operand bundle and float16 field helpers.
package fma16_pkg;
  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;
  localparam logic [1:0] RM_RZ  = 2'd0;
  localparam logic [1:0] RM_RNE = 2'd1;
  localparam logic [1:0] RM_DN  = 2'd2;
  localparam logic [1:0] RM_UP  = 2'd3;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [5:0]  ctrl;
  } bundle_t;
  function automatic logic [10:0] sig(input logic [14:0] v);
    return {|v[14:10], v[9:0]};
  endfunction
  function automatic logic [5:0] ex(input logic [4:0] e);
    return {1'b0, e | {4'b0, ~|e}};
  endfunction
  function automatic logic is_nan(input logic [14:0] v);
    return &v[14:10] && |v[9:0];
  endfunction
  function automatic logic is_snan(input logic [14:0] v);
    return is_nan(v) && !v[9];
  endfunction
  function automatic logic is_inf(input logic [14:0] v);
    return &v[14:10] && ~|v[9:0];
  endfunction
  function automatic logic is_zero(input logic [14:0] v);
    return ~|v[14:0];
  endfunction
endpackage

// File: rtl/fma16.sv
// fma16: half-precision fused multiply-add, x*y+z computed exactly on an 81-bit fixed-point grid then rounded once.
module fma16 import fma16_pkg::*; (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  input  logic [1:0]  roundmode,
  output logic [15:0] result,
  output logic [3:0]  flags
);
  logic [15:0] b, c;
  logic ps, zs, rs, same, pge, g, s, inc, ovf, inf_r, nan_a, pinf, inv;
  logic [10:0] sx, sb, sc, kept;
  logic [21:0] prod;
  logic [80:0] p, q, mag;
  logic [6:0] m, lsb;
  logic [16:0] enc;
  assign b = mul ? y : 16'h3c00;
  assign ps = x[15] ^ b[15] ^ negp;
  // a disabled addend is a zero signed like the product, so it never disturbs the result
  assign c = add ? z : {ps ^ negz, 15'h0};
  assign zs = c[15] ^ negz;
  assign sx = sig(x[14:0]);
  assign sb = sig(b[14:0]);
  assign sc = sig(c[14:0]);
  assign prod = {11'b0, sx} * {11'b0, sb};
  assign p = {59'b0, prod} << (ex(x[14:10]) + ex(b[14:10]) - 6'd2);
  assign q = {70'b0, sc} << (ex(c[14:10]) + 6'd23);
  assign same = ps == zs;
  assign pge = p >= q;
  assign mag = same ? p + q : pge ? p - q : q - p;
  assign rs = same | pge ? ps : zs;
  always_comb begin
    m = '0;
    for (int i = 0; i < 81; i++) if (mag[i]) m = 7'(i);
  end
  // bit 24 of mag weighs 2^-24, the subnormal LSB; normals keep 11 bits below the leading one
  assign lsb = m >= 7'd34 ? m - 7'd10 : 7'd24;
  assign kept = 11'(mag >> lsb);
  assign g = mag[lsb - 7'd1];
  assign s = |(mag & ((81'd1 << (lsb - 7'd1)) - 81'd1));
  assign inc = roundmode == RM_RNE ? g & (s | kept[0]) :
               roundmode == RM_RZ ? 1'b0 : ((roundmode == RM_DN) == rs) & (g | s);
  assign enc = ((m >= 7'd34 ? 17'(m - 7'd34) : 17'd0) << 10) + 17'(kept) + 17'(inc);
  assign ovf = enc >= 17'h7c00;
  assign inf_r = roundmode == RM_RNE || (roundmode != RM_RZ && (roundmode == RM_DN) == rs);
  assign nan_a = is_nan(x[14:0]) | is_nan(b[14:0]) | is_nan(c[14:0]);
  assign pinf = is_inf(x[14:0]) | is_inf(b[14:0]);
  assign inv = is_snan(x[14:0]) | is_snan(b[14:0]) | is_snan(c[14:0]) |
               (is_inf(x[14:0]) & is_zero(b[14:0])) | (is_zero(x[14:0]) & is_inf(b[14:0])) |
               (pinf & is_inf(c[14:0]) & !same & !nan_a);
  always_comb begin
    flags = '0;
    result = {rs, enc[14:0]};
    if (nan_a | inv) begin
      result = 16'h7e00;
      flags[FLG_NV] = inv;
    end else if (pinf) result = {ps, 15'h7c00};
    else if (is_inf(c[14:0])) result = {zs, 15'h7c00};
    else if (mag == '0) result = {same ? ps : roundmode == RM_DN, 15'h0};
    else if (ovf) begin
      result = {rs, inf_r ? 15'h7c00 : 15'h7bff};
      flags[FLG_OF] = 1'b1;
      flags[FLG_NX] = 1'b1;
    end else begin
      flags[FLG_UF] = m < 7'd34 && (g | s);
      flags[FLG_NX] = g | s;
    end
  end
endmodule

// File: rtl/fma16_pipe.sv
// fma16_pipe: FIFO-buffered, output-registered fma16 with valid/ready handshakes.
// Define FMA16_STICKY_FLAGS_EN to add the sticky_flags accumulator and its flags_clr input.
module fma16_pipe import fma16_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic [5:0]  ctrl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [3:0]  flags
`ifdef FMA16_STICKY_FLAGS_EN
  ,
  output logic [3:0]  sticky_flags,
  input  logic        flags_clr
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  bundle_t mem [DEPTH];
  bundle_t hd;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic live, push, pop;
  logic [15:0] f_res;
  logic [3:0] f_flg;
  // live keeps in_ready low through reset and for the cycle it is released
  assign in_ready = live && cnt != FULL;
  assign push = in_valid && in_ready;
  assign pop = cnt != '0 && (!out_valid || out_ready);
  assign hd = mem[rp];
  fma16 u_fma (
    .x(hd.x), .y(hd.y), .z(hd.z),
    .mul(hd.ctrl[3]), .add(hd.ctrl[2]), .negp(hd.ctrl[1]), .negz(hd.ctrl[0]),
    .roundmode(hd.ctrl[5:4]), .result(f_res), .flags(f_flg)
  );
  always_ff @(posedge clk)
    if (push) mem[wp] <= {x, y, z, ctrl};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      live <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      result <= '0;
      flags <= '0;
    end else begin
      live <= 1'b1;
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) begin
        out_valid <= 1'b1;
        result <= f_res;
        flags <= f_flg;
      end else if (out_ready) out_valid <= 1'b0;
    end
`ifdef FMA16_STICKY_FLAGS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) sticky_flags <= '0;
    else if (flags_clr) sticky_flags <= pop ? f_flg : 4'b0;
    else if (pop) sticky_flags <= sticky_flags | f_flg;
`endif
endmodule

// File: tb/tb_fma16_pipe.sv
// tb_fma16_pipe: directed arithmetic, backpressure, reset and random-stream checks for fma16_pipe.
module tb_fma16_pipe;
  import fma16_pkg::*;
  logic clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [15:0] x = 0, y = 0, z = 0, result, r_res;
  logic [5:0] ctrl = 0;
  logic [3:0] flags, r_flg;
`ifdef FMA16_STICKY_FLAGS_EN
  logic [3:0] sticky_flags;
  logic flags_clr = 0;
`endif
  int n_chk = 0, n_fail = 0;
  logic [19:0] q[$];
  always #5 clk = ~clk;
  fma16_pipe #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
`ifdef FMA16_STICKY_FLAGS_EN
    , .sticky_flags(sticky_flags), .flags_clr(flags_clr)
`endif
  );
  fma16 u_ref (
    .x(x), .y(y), .z(z), .mul(ctrl[3]), .add(ctrl[2]), .negp(ctrl[1]), .negz(ctrl[0]),
    .roundmode(ctrl[5:4]), .result(r_res), .flags(r_flg)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [5:0] k,
                         input logic [15:0] er, input logic [3:0] ef);
    @(posedge clk); #1;
    x = a; y = b; z = c; ctrl = k; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check({tag, "_lat"}, 32'(out_valid), 0);
    @(posedge clk); #1;
    check({tag, "_v"}, 32'(out_valid), 1);
    check({tag, "_r"}, 32'(result), 32'(er));
    check({tag, "_f"}, 32'(flags), 32'(ef));
  endtask
  initial begin
    int n, sent, got, seen;
    logic acc;
    #1 reset = 1;
    #1;
    check("rst_ready", 32'(in_ready), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_result", 32'(result), 0);
    check("rst_flags", 32'(flags), 0);
`ifdef FMA16_STICKY_FLAGS_EN
    check("rst_sticky", 32'(sticky_flags), 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    #1 check("rel_ready_lo", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("rel_ready_hi", 32'(in_ready), 1);
    run_vec("fma_basic", 16'h3c00, 16'h4000, 16'h3c00, 6'h1c, 16'h4200, 4'b0000);
    run_vec("ovf_rne",   16'h7bff, 16'h7bff, 16'h0000, 6'h1c, 16'h7c00, 4'b0101);
`ifdef FMA16_STICKY_FLAGS_EN
    run_vec("exact_op",  16'h3e00, 16'h3e00, 16'h0000, 6'h18, 16'h4080, 4'b0000);
    check("sticky_acc", 32'(sticky_flags), 32'h5);
    @(posedge clk); #1 flags_clr = 1;
    @(posedge clk); #1 flags_clr = 0;
    check("sticky_clr", 32'(sticky_flags), 0);
`endif
    run_vec("inf_x_0",   16'h7c00, 16'h0000, 16'h0000, 6'h1c, 16'h7e00, 4'b1000);
    run_vec("ovf_rz",    16'h7bff, 16'h7bff, 16'h0000, 6'h0c, 16'h7bff, 4'b0101);
    run_vec("ovf_dn",    16'hfbff, 16'h7bff, 16'h0000, 6'h2c, 16'hfc00, 4'b0101);
    run_vec("cancel_rne", 16'h3c00, 16'h3c00, 16'h3c00, 6'h1d, 16'h0000, 4'b0000);
    run_vec("cancel_dn", 16'h3c00, 16'h3c00, 16'h3c00, 6'h2d, 16'h8000, 4'b0000);
    run_vec("exact_mul", 16'h3e00, 16'h3e00, 16'h0000, 6'h18, 16'h4080, 4'b0000);
    run_vec("nx_rne",    16'h3c01, 16'h3c01, 16'h0000, 6'h18, 16'h3c02, 4'b0001);
    run_vec("nx_rp",     16'h3c01, 16'h3c01, 16'h0000, 6'h38, 16'h3c03, 4'b0001);
    run_vec("sub_exact", 16'h0400, 16'h3800, 16'h0000, 6'h18, 16'h0200, 4'b0000);
    run_vec("sub_uf",    16'h0401, 16'h3800, 16'h0000, 6'h18, 16'h0200, 4'b0011);
    run_vec("snan",      16'h7d00, 16'h3c00, 16'h0000, 6'h18, 16'h7e00, 4'b1000);
    run_vec("qnan",      16'h7e00, 16'h3c00, 16'h0000, 6'h18, 16'h7e00, 4'b0000);
    run_vec("inf_m_inf", 16'h7c00, 16'h3c00, 16'hfc00, 6'h1c, 16'h7e00, 4'b1000);
    run_vec("inf_p_one", 16'h7c00, 16'h3c00, 16'h3c00, 6'h1c, 16'h7c00, 4'b0000);
    run_vec("negp",      16'h3c00, 16'h4000, 16'h0000, 6'h1a, 16'hc000, 4'b0000);
    run_vec("no_mul",    16'h4000, 16'h1234, 16'h3c00, 6'h14, 16'h4200, 4'b0000);
    // backpressure: result register plus four FIFO entries, then in order release
    @(posedge clk); #1;
    out_ready = 0; in_valid = 1; x = 16'h4000; y = 16'h3c00; z = 0; ctrl = 6'h18;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk) acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        n++;
        x = 16'h4000 + 16'(n);
      end
    end
    check("bp_accepted", 32'(n), 5);
    check("bp_ready", 32'(in_ready), 0);
    check("bp_hold", 32'(result), 32'h4000);
    out_ready = 1;
    #1 check("bp_full_pop_ready", 32'(in_ready), 0);
    in_valid = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_order", 32'(result), 32'h4000 + 32'(k));
    end
    @(negedge clk) check("bp_drained", 32'(out_valid), 0);
    // reset with three bundles queued behind a held result
    @(posedge clk); #1;
    out_ready = 0; in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      x = 16'h4100 + 16'(k);
      @(posedge clk); #1;
    end
    in_valid = 0;
    check("rq_valid", 32'(out_valid), 1);
    #2 reset = 1;
    #1;
    check("rq_rst_valid", 32'(out_valid), 0);
    check("rq_rst_ready", 32'(in_ready), 0);
    check("rq_rst_result", 32'(result), 0);
    @(negedge clk) reset = 0;
    out_ready = 1;
    @(posedge clk); #1 check("rq_rel_ready", 32'(in_ready), 1);
    seen = 0;
    repeat (6) @(negedge clk) if (out_valid) seen++;
    check("rq_no_stale", 32'(seen), 0);
    // random stream against the standalone reference, random handshakes
    sent = 0; got = 0; out_ready = 0; in_valid = 0;
    for (int cyc = 0; cyc < 20000 && (sent < 1000 || q.size() != 0); cyc++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        q.push_back({r_res, r_flg});
        sent++;
      end
      if (out_valid && out_ready) begin
        got++;
        if (q.size() == 0) check("stream_extra", 32'(q.size()), 1);
        else check("stream", 32'({result, flags}), 32'(q.pop_front()));
      end
      @(posedge clk); #1;
      out_ready = $urandom_range(0, 3) != 0;
      in_valid = sent < 1000 && $urandom_range(0, 3) != 0;
      x = 16'($urandom); y = 16'($urandom); z = 16'($urandom); ctrl = 6'($urandom);
    end
    in_valid = 0;
    check("stream_sent", 32'(sent), 1000);
    check("stream_got", 32'(got), 1000);
    check("stream_drain", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
